// File: rtl/cpu_ctrl_fsm_if.sv
// Instruction-memory fetch bus between cpu_ctrl_fsm (master) and the instruction store (slave).
// Handshake: the master holds imem_req high with imem_addr stable until the slave returns imem_valid with imem_rdata; a word is taken only in a cycle where both imem_req and imem_valid are 1.
interface cpu_ctrl_fsm_if #(
    parameter int PC_WIDTH = 16
);
    logic [PC_WIDTH-1:0] imem_addr;
    logic                imem_req;
    logic [15:0]         imem_rdata;
    logic                imem_valid;

    modport master (
        output imem_addr,
        output imem_req,
        input  imem_rdata,
        input  imem_valid
    );

    modport slave (
        input  imem_addr,
        input  imem_req,
        output imem_rdata,
        output imem_valid
    );
endinterface

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control unit for the 16-bit ALU: fetch, decode, execute, writeback, one state per phase.
// Optional single-step input is enabled by defining CPU_CTRL_STEP_EN.
module cpu_ctrl_fsm #(
    parameter int                  PC_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef CPU_CTRL_STEP_EN
    input  logic                  step,
`endif
    cpu_ctrl_fsm_if.master        imem,
    output logic [2:0]            rs_addr,
    output logic [2:0]            rt_addr,
    output logic [2:0]            rd_addr,
    output logic                  reg_we,
    output logic                  wb_sel,
    output logic [2:0]            alu_op,
    output logic [15:0]           imm,
    input  logic                  alu_zero,
    output logic                  halted,
    output logic [2:0]            state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_e;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_NOT   = 3'b100;
    localparam logic [2:0] OP_LOADI = 3'b101;
    localparam logic [2:0] OP_BEQ   = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [15:0]         ir_q, ir_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic                wb_sel_q, wb_sel_d;
    logic [2:0]          alu_op_q, alu_op_d;
    logic [15:0]         imm_q, imm_d;
    logic [2:0]          rs_q, rs_d;
    logic [2:0]          rt_q, rt_d;
    logic [2:0]          rd_q, rd_d;
    logic                halted_q, halted_d;

    logic                step_ok;
    logic [2:0]          opcode;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] br_off;

`ifdef CPU_CTRL_STEP_EN
    assign step_ok = step;
`else
    assign step_ok = 1'b1;
`endif

    assign opcode = ir_q[15:13];
    assign pc_inc = pc_q + PC_WIDTH'(1);
    assign br_off = {{(PC_WIDTH-4){ir_q[3]}}, ir_q[3:0]};

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        req_d    = req_q;
        we_d     = 1'b0;
        wb_sel_d = wb_sel_q;
        alu_op_d = alu_op_q;
        imm_d    = imm_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        rd_d     = rd_q;
        halted_d = halted_q;

        case (state_q)
            S_IDLE: begin
                if (step_ok) begin
                    state_d = S_FETCH;
                    req_d   = 1'b1;
                end
            end
            S_FETCH: begin
                // Request may still be parked low here, waiting for a step pulse.
                if (!req_q) begin
                    req_d = step_ok;
                end else if (imem.imem_valid) begin
                    ir_d    = imem.imem_rdata;
                    req_d   = 1'b0;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                rd_d     = ir_q[12:10];
                rs_d     = ir_q[9:7];
                rt_d     = ir_q[6:4];
                imm_d    = {6'b0, ir_q[9:0]};
                wb_sel_d = (opcode == OP_LOADI);
                if (opcode == OP_BEQ) begin
                    alu_op_d = OP_SUB;
                end else if (opcode <= OP_NOT) begin
                    alu_op_d = opcode;
                end else begin
                    alu_op_d = OP_ADD;
                end
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                case (opcode)
                    OP_BEQ: begin
                        pc_d    = alu_zero ? (pc_inc + br_off) : pc_inc;
                        req_d   = step_ok;
                        state_d = S_FETCH;
                    end
                    OP_HALT: begin
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end
                    default: begin
                        we_d    = 1'b1;
                        state_d = S_WRITEBACK;
                    end
                endcase
            end
            S_WRITEBACK: begin
                pc_d    = pc_inc;
                req_d   = step_ok;
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            wb_sel_q <= 1'b0;
            alu_op_q <= 3'b000;
            imm_q    <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            req_q    <= req_d;
            we_q     <= we_d;
            wb_sel_q <= wb_sel_d;
            alu_op_q <= alu_op_d;
            imm_q    <= imm_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            rd_q     <= rd_d;
            halted_q <= halted_d;
        end
    end

    assign imem.imem_addr = pc_q;
    assign imem.imem_req  = req_q;
    assign rs_addr        = rs_q;
    assign rt_addr        = rt_q;
    assign rd_addr        = rd_q;
    assign reg_we         = we_q;
    assign wb_sel         = wb_sel_q;
    assign alu_op         = alu_op_q;
    assign imm            = imm_q;
    assign halted         = halted_q;
    assign state          = state_q;

endmodule
